// File: rtl/roll_trace_buffer_pkg.sv
// Shared constants, column entry type and sample-to-row scaler for the rolling trace buffer.
package roll_trace_buffer_pkg;
    localparam int SAMPLE_W = 12;
    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int PROD_W   = SAMPLE_W + Y_W + 1;

    typedef struct packed {
        logic [Y_W-1:0] y_lo;
        logic [Y_W-1:0] y_hi;
    } col_entry_t;

    // Full-scale sample maps to the top row, zero to the bottom row.
    function automatic logic [Y_W-1:0] scale_to_row(input logic [SAMPLE_W-1:0] s);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(s) * PROD_W'(V_RES);
        return Y_W'(V_RES - 1) - Y_W'(prod >> SAMPLE_W);
    endfunction
endpackage

// File: rtl/roll_trace_buffer_if.sv
// Sample-write and VGA-scan signal bundle between the trace buffer and its neighbours.
interface roll_trace_buffer_if;
    import roll_trace_buffer_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_stb;
    logic                freeze;
    logic                frame_start;
    logic                vga_req;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic                pixel_on;
    logic                pixel_valid;
    logic [X_W-1:0]      wr_ptr;
    logic                filled;

    modport master (
        output sample_in, sample_stb, freeze, frame_start, vga_req, vga_x, vga_y,
        input  pixel_on, pixel_valid, wr_ptr, filled
    );
    modport slave (
        input  sample_in, sample_stb, freeze, frame_start, vga_req, vga_x, vga_y,
        output pixel_on, pixel_valid, wr_ptr, filled
    );
endinterface

// File: rtl/roll_trace_buffer_col_ram.sv
// Simple dual-port per-column span memory; registered read, read-first on address collision.
module roll_trace_buffer_col_ram
    import roll_trace_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           i_we,
    input  logic [X_W-1:0] i_waddr,
    input  col_entry_t     i_wdata,
    input  logic [X_W-1:0] i_raddr,
    output col_entry_t     o_rdata
);
    col_entry_t r_mem [H_RES];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/roll_trace_buffer.sv
// Scales decimated samples to rows, stores min/max spans per column and serves a scrolling trace pixel.
module roll_trace_buffer
    import roll_trace_buffer_pkg::*;
(
    input logic              clk,
    input logic              rst,
    roll_trace_buffer_if.slave bus
);
    logic           r_s1_vld, r_first, r_filled;
    logic [Y_W-1:0] r_s1_y, r_prev_y;
    logic [X_W-1:0] r_wr_ptr, r_base;
    logic [X_W-1:0] r_r1_addr;
    logic [Y_W-1:0] r_r1_y, r_r2_y;
    logic           r_r1_req, r_r1_ok, r_r2_req, r_r2_ok;

    col_entry_t     w_wdata, w_rdata;
    logic [Y_W-1:0] w_prev;
    logic [X_W:0]   w_sum, w_wrap;
    logic [X_W-1:0] w_raddr;
    logic           w_x_ok, w_take;

    assign w_take = bus.sample_stb && !bus.freeze;
    assign w_x_ok = bus.vga_x < X_W'(H_RES);

    always_comb begin
        w_prev       = r_first ? r_s1_y : r_prev_y;
        w_wdata.y_lo = (r_s1_y < w_prev) ? r_s1_y : w_prev;
        w_wdata.y_hi = (r_s1_y < w_prev) ? w_prev : r_s1_y;
        w_sum        = {1'b0, r_base} + {1'b0, bus.vga_x};
        w_wrap       = (w_sum >= (X_W+1)'(H_RES)) ? w_sum - (X_W+1)'(H_RES) : w_sum;
        // Out-of-range columns park the read on column 0; the result is masked anyway.
        w_raddr      = '0;
        if (w_x_ok)
            w_raddr = r_filled ? w_wrap[X_W-1:0] : bus.vga_x;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_y   <= '0;
            r_prev_y <= '0;
            r_first  <= 1'b1;
            r_wr_ptr <= '0;
            r_filled <= 1'b0;
        end else begin
            r_s1_vld <= w_take;
            if (w_take)
                r_s1_y <= scale_to_row(bus.sample_in);
            if (r_s1_vld) begin
                r_prev_y <= r_s1_y;
                r_first  <= 1'b0;
                if (r_wr_ptr == X_W'(H_RES - 1)) begin
                    r_wr_ptr <= '0;
                    r_filled <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end
        end
    end

    // Base is sampled once per frame so the picture never tears mid-scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_base <= '0;
        else if (bus.frame_start)
            r_base <= r_filled ? r_wr_ptr : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r1_addr <= '0;
            r_r1_y    <= '0;
            r_r1_req  <= 1'b0;
            r_r1_ok   <= 1'b0;
            r_r2_y    <= '0;
            r_r2_req  <= 1'b0;
            r_r2_ok   <= 1'b0;
        end else begin
            r_r1_addr <= w_raddr;
            r_r1_y    <= bus.vga_y;
            r_r1_req  <= bus.vga_req;
            r_r1_ok   <= w_x_ok;
            r_r2_y    <= r_r1_y;
            r_r2_req  <= r_r1_req;
            r_r2_ok   <= r_r1_ok && (r_filled || (r_r1_addr < r_wr_ptr));
        end
    end

    roll_trace_buffer_col_ram u_ram (
        .clk     (clk),
        .i_we    (r_s1_vld),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_r1_addr),
        .o_rdata (w_rdata)
    );

    assign bus.pixel_on    = r_r2_req && r_r2_ok &&
                             (w_rdata.y_lo <= r_r2_y) && (r_r2_y <= w_rdata.y_hi);
    assign bus.pixel_valid = r_r2_req;
    assign bus.wr_ptr      = r_wr_ptr;
    assign bus.filled      = r_filled;
endmodule
